div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, which the single-cycle ALU does not implement. Sits in the EX stage beside the ALU and takes the same forwarded Operand1/Operand2. It holds the pipeline via `busy` while computing. On `done`, it drives the EX-stage result mux that feeds the EX/MEM register. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with single-cycle fast paths for the special cases.

---
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow skip the iteration.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  DivType,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] DivOut
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_rem_q, is_rem_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] out_q, out_d;

    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        op_signed = ~DivType[0];
        a_neg     = op_signed & Operand1[31];
        b_neg     = op_signed & Operand2[31];
        abs_a     = a_neg ? (~Operand1 + 32'd1) : Operand1;
        abs_b     = b_neg ? (~Operand2 + 32'd1) : Operand2;

        // 33-bit trial keeps the compare correct when the divisor has bit 31 set
        trial     = {rem_q, quo_q[31]} - {1'b0, dvs_q};

        quo_res   = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
        rem_res   = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        out_d     = out_q;

        unique case (state_q)
            IDLE: begin
                if (!flush && start) begin
                    is_rem_d  = DivType[1];
                    dvs_d     = abs_b;
                    cnt_d     = '0;
                    rem_neg_d = a_neg;
                    // Special cases preload quo/rem so the common sign fix-up yields
                    // the architected result without a separate result path.
                    if (Operand2 == 32'd0) begin
                        quo_neg_d = 1'b0;
                        quo_d     = '1;
                        rem_d     = abs_a;
                        state_d   = DONE;
                    end else if (op_signed && Operand1 == 32'h8000_0000 &&
                                 Operand2 == 32'hFFFF_FFFF) begin
                        quo_neg_d = 1'b0;
                        quo_d     = 32'h8000_0000;
                        rem_d     = '0;
                        state_d   = DONE;
                    end else begin
                        quo_neg_d = a_neg ^ b_neg;
                        quo_d     = abs_a;
                        rem_d     = '0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
                    quo_d = {quo_q[30:0], ~trial[32]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    out_d  = is_rem_q ? rem_res : quo_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done/DivOut are registered on the edge leaving DONE; busy spans that pulse too
    assign busy   = (state_q != IDLE) | done_q;
    assign done   = done_q;
    assign DivOut = out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected results, a monitor
// compares value and arrival cycle whenever done is seen.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  DivType;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] DivOut;

    localparam logic [1:0] T_DIV  = 2'b00;
    localparam logic [1:0] T_DIVU = 2'b01;
    localparam logic [1:0] T_REM  = 2'b10;
    localparam logic [1:0] T_REMU = 2'b11;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .DivType  (DivType),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .DivOut   (DivOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d DivOut=%08h (no response expected)", cyc, DivOut);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks += 2;
                if (DivOut !== e.val) begin
                    failures++;
                    $display("FAIL %s value: got %08h expected %08h", e.name, DivOut, e.val);
                end
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s latency: done at cycle %0d expected %0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_resp, input logic [31:0] want, input int lat,
                         input string name);
        exp_t e;
        DivType  = t;
        Operand1 = a;
        Operand2 = b;
        start    = 1'b1;
        if (expect_resp) begin
            e.val  = want;
            e.cyc  = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        tick();
        start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        DivType  = 2'($urandom);
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
        end
    endtask

    task automatic run(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input int lat, input string name);
        int n;
        issue(t, a, b, 1'b1, want, lat, name);
        wait_idle(name, n);
        checks++;
        if (n != lat) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, lat);
        end
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        DivType  = T_DIVU;
        Operand1 = '0;
        Operand2 = '0;
        #23;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_divout", DivOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run(T_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        run(T_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
        run(T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        run(T_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run(T_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
        run(T_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");
        run(T_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 34, "divu_big");
        run(T_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34, "remu_big");
        run(T_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_noovf");
        run(T_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_5_0");
        run(T_REM, 32'd5, 32'd0, 32'd5, 2, "rem_5_0");
        run(T_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, "rem_m7_0");
        run(T_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 2, "divu_7_0");
        run(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
        run(T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");

        // A start pulse mid-operation must be ignored.
        issue(T_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34, "divu_ignore_start");
        repeat (9) tick();
        DivType  = T_DIV;
        Operand1 = 32'd55;
        Operand2 = 32'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_idle("divu_ignore_start", n);
        tick();

        // Flush aborts without done and leaves DivOut at 14.
        issue(T_DIVU, 32'd50, 32'd5, 1'b0, 32'd0, 0, "flushed");
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_divout", DivOut, 32'd14);
        repeat (40) tick();

        // flush wins over start in IDLE.
        DivType  = T_DIVU;
        Operand1 = 32'd9;
        Operand2 = 32'd3;
        start    = 1'b1;
        flush    = 1'b1;
        tick();
        start    = 1'b0;
        flush    = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) tick();
        check("flush_start_divout", DivOut, 32'd14);

        // Asynchronous reset mid-operation clears outputs immediately.
        issue(T_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "reset_abort");
        repeat (14) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_divout", DivOut, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        run(T_DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_9_3");

        repeat (5) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_responses: got %0d outstanding expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
